// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI command sequencer.
// Holds the FSM state encoding, wait-counter width and the length-mask helper.
package spi_seq_pkg;

    localparam int SEQ_LEN_WIDTH = 8;
    localparam int WAIT_WIDTH    = SEQ_LEN_WIDTH + 9;
    // Widest mask any 8-bit length can describe; callers truncate.
    localparam int LEN_MASK_MAX  = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } seq_state_t;

    // Ones in bit positions [length-1:0].
    function automatic logic [LEN_MASK_MAX-1:0] len_mask(
        input int unsigned length
    );
        logic [LEN_MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LEN_MASK_MAX; i++) begin
            m[i] = (i < length);
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_wait_timer.sv
// Down-counter timing out one SPI transfer.
// Ports: clk_i, rst_i (async high), load_i/load_value_i, expire_o (count==1).
module spi_wait_timer
    import spi_seq_pkg::*;
#(
    parameter int WIDTH = WAIT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Asserted during the last cycle of the wait window.
    assign expire_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/spi_command_sequencer.sv
// Command front end for the SPI core: one command in flight, pulse, wait, respond.
// Ports: cmd_* in (valid/ready), xfer_* to/from core, rsp_* out, busy, err_len.
module spi_command_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 8,
    parameter int TAG_WIDTH             = 4,
    parameter int GUARD_CYCLES          = 16
) (
    input  logic                             fabric_clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
    input  logic [DATA_WIDTH-1:0]            cmd_data,
    input  logic [DATA_WIDTH-1:0]            cmd_mask,
    input  logic [TAG_WIDTH-1:0]             cmd_tag,
    input  logic [7:0]                       clks_per_bit,
    output logic [TRANSACTION_LEN_WIDTH-1:0] xfer_length,
    output logic [DATA_WIDTH-1:0]            xfer_data,
    output logic [DATA_WIDTH-1:0]            xfer_mask,
    input  logic [DATA_WIDTH-1:0]            xfer_read_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    output logic                             busy,
    output logic                             err_len
);

    localparam int CNT_W = TRANSACTION_LEN_WIDTH + 9;

    seq_state_t                       state_q;
    logic [TRANSACTION_LEN_WIDTH-1:0] len_q;
    logic [TRANSACTION_LEN_WIDTH-1:0] xfer_len_q;
    logic [TAG_WIDTH-1:0]             tag_q;
    logic [TAG_WIDTH-1:0]             rsp_tag_q;
    logic [DATA_WIDTH-1:0]            xfer_data_q;
    logic [DATA_WIDTH-1:0]            xfer_mask_q;
    logic [DATA_WIDTH-1:0]            rsp_data_q;
    logic                             rsp_valid_q;
    logic                             err_len_q;

    logic [DATA_WIDTH-1:0] lenmask;
    logic                  has_read;
    logic [7:0]            cpb_eff;
    logic [CNT_W-1:0]      wait_d;
    logic                  cmd_fire;
    logic                  len_zero;
    logic                  len_over;
    logic                  expire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign len_zero = (cmd_length == '0);
    assign len_over = 32'(cmd_length) > DATA_WIDTH;

    assign lenmask  = DATA_WIDTH'(len_mask(32'(len_q)));
    // Any mask zero inside the active length is a read bit.
    assign has_read = (xfer_mask_q | ~lenmask) != '1;

    assign cpb_eff  = (clks_per_bit == 8'd0) ? 8'd1 : clks_per_bit;
    assign wait_d   = CNT_W'(len_q) * CNT_W'(cpb_eff)
                    + CNT_W'(GUARD_CYCLES);

    spi_wait_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk_i       (fabric_clk),
        .rst_i       (reset),
        .load_i      (state_q == S_ISSUE),
        .load_value_i(wait_d),
        .expire_o    (expire)
    );

    always_ff @(posedge fabric_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            xfer_len_q  <= '0;
            tag_q       <= '0;
            rsp_tag_q   <= '0;
            xfer_data_q <= '0;
            xfer_mask_q <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (len_over) begin
                            err_len_q <= 1'b1;
                        end else if (!len_zero) begin
                            len_q       <= cmd_length;
                            tag_q       <= cmd_tag;
                            xfer_len_q  <= cmd_length;
                            xfer_data_q <= cmd_data;
                            xfer_mask_q <= cmd_mask;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Length is a one-cycle trigger for the core.
                    xfer_len_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (expire) begin
                        if (has_read) begin
                            rsp_data_q  <= xfer_read_data
                                         & ~xfer_mask_q & lenmask;
                            rsp_tag_q   <= tag_q;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE) && !reset;
    assign busy        = (state_q != S_IDLE);
    assign xfer_length = xfer_len_q;
    assign xfer_data   = xfer_data_q;
    assign xfer_mask   = xfer_mask_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Scoreboard bench for spi_command_sequencer with a bit-level reference model.
// Driver pushes expected pulses/responses; a monitor pops and compares them.
module tb_spi_command_sequencer;

    localparam int GUARD = 16;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_length;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic [3:0]  cmd_tag;
    logic [7:0]  clks_per_bit;
    logic [7:0]  xfer_length;
    logic [31:0] xfer_data;
    logic [31:0] xfer_mask;
    logic [31:0] xfer_read_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic        err_len;

    spi_command_sequencer dut (
        .fabric_clk    (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_length    (cmd_length),
        .cmd_data      (cmd_data),
        .cmd_mask      (cmd_mask),
        .cmd_tag       (cmd_tag),
        .clks_per_bit  (clks_per_bit),
        .xfer_length   (xfer_length),
        .xfer_data     (xfer_data),
        .xfer_mask     (xfer_mask),
        .xfer_read_data(xfer_read_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .busy          (busy),
        .err_len       (err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] d;
        logic [31:0] m;
        int          lat;
    } xexp_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  tag;
    } rexp_t;

    xexp_t xq[$];
    rexp_t rq[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_err  = 1'b0;
    bit   pend     = 1'b0;
    int   pend_cyc = 0;
    int   pend_lat = 0;
    int   cyc      = 0;
    int   stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got timeout expected event",
                 name);
    endtask

    // Reference model: bit-by-bit from the command rules.
    task automatic model(input int len, input logic [31:0] d,
                         input logic [31:0] m, input logic [3:0] tag,
                         input logic [31:0] rd);
        xexp_t x;
        rexp_t r;
        bit    rdbits;
        int    cpb;
        if (len > 32) exp_err = 1'b1;
        if (len == 0 || len > 32) return;
        cpb    = (clks_per_bit == 0) ? 1 : int'(clks_per_bit);
        x.len  = len;
        x.d    = d;
        x.m    = m;
        x.lat  = len * cpb + GUARD + 1;
        xq.push_back(x);
        rdbits = 1'b0;
        r.d    = '0;
        r.tag  = tag;
        for (int i = 0; i < len; i++) begin
            if (!m[i]) begin
                rdbits = 1'b1;
                r.d[i] = rd[i];
            end
        end
        if (rdbits) rq.push_back(r);
    endtask

    task automatic send(input int len, input logic [31:0] d,
                        input logic [31:0] m, input logic [3:0] tag,
                        input logic [31:0] rd, output int waits);
        waits = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_length = 8'(len);
        cmd_data   = d;
        cmd_mask   = m;
        cmd_tag    = tag;
        while (!cmd_ready && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            note_fail("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model(len, d, m, tag, rd);
        #1;
        cmd_valid      = 1'b0;
        xfer_read_data = rd;
        chk("err_len", 64'(err_len), 64'(exp_err));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && rsp_valid === 1'b0 &&
                     xq.size() == 0 && rq.size() == 0 && !pend)
                   && n < LIMIT);
        if (n >= LIMIT) note_fail("wait_idle");
        else chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    // rsp_ready driver: random, or forced low for stall_left cycles
    // of rsp_valid.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) stall_left--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor.
    initial begin
        bit          prev_pulse = 0;
        bit          stalled    = 0;
        bit          after_hs   = 0;
        logic [31:0] s_data;
        logic [3:0]  s_tag;
        xexp_t       x;
        rexp_t       r;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_pulse = 0;
                stalled    = 0;
                after_hs   = 0;
                continue;
            end
            if (prev_pulse) chk("pulse_width", 64'(xfer_length), 64'd0);
            prev_pulse = 0;
            if (after_hs) begin
                chk("post_hs_valid", 64'(rsp_valid), 64'd0);
                chk("post_hs_ready", 64'(cmd_ready), 64'd1);
            end
            after_hs = 0;
            if (xfer_length != 0) begin
                prev_pulse = 1;
                if (xq.size() == 0) begin
                    chk("xfer_unexpected", 64'(xfer_length), 64'd0);
                end else begin
                    x = xq.pop_front();
                    chk("xfer_len", 64'(xfer_length), 64'(x.len));
                    chk("xfer_data", 64'(xfer_data), 64'(x.d));
                    chk("xfer_mask", 64'(xfer_mask), 64'(x.m));
                    pend     = 1;
                    pend_cyc = cyc;
                    pend_lat = x.lat;
                end
            end else if (pend && (rsp_valid || !busy)) begin
                chk("latency", 64'(cyc - pend_cyc), 64'(pend_lat));
                pend = 0;
            end
            if (rsp_valid) begin
                chk("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
                if (stalled) begin
                    chk("stall_data", 64'(rsp_data), 64'(s_data));
                    chk("stall_tag", 64'(rsp_tag), 64'(s_tag));
                end
                stalled = !rsp_ready;
                s_data  = rsp_data;
                s_tag   = rsp_tag;
                if (rsp_ready) begin
                    after_hs = 1;
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("rsp_data", 64'(rsp_data), 64'(r.d));
                        chk("rsp_tag", 64'(rsp_tag), 64'(r.tag));
                    end
                end
            end else begin
                stalled = 0;
            end
        end
    end

    // Stimulus.
    initial begin
        int          w;
        int          n;
        int          len;
        logic [31:0] m;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_length     = '0;
        cmd_data       = '0;
        cmd_mask       = '0;
        cmd_tag        = '0;
        clks_per_bit   = 8'd4;
        xfer_read_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_xfer_len", 64'(xfer_length), 64'd0);
        chk("rst_xfer_data", 64'(xfer_data), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_len), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Write-only.
        send(8, 32'hA5, 32'hFF, 4'd1, 32'h1234_5678, w);
        wait_idle();

        // Mixed read.
        send(16, 32'h3C00, 32'hFF00, 4'd5, 32'hFFFF, w);
        wait_idle();

        // Backpressure with a queued second command.
        stall_left = 20;
        send(12, 32'h0, 32'h0F0, 4'd9, 32'hABC, w);
        send(8, 32'h5A, 32'hFF, 4'd3, 32'h0, w);
        wait_idle();

        // Illegal lengths then a legal command.
        send(0, 32'h1, 32'h0, 4'd2, 32'h0, w);
        send(40, 32'h1, 32'h0, 4'd2, 32'h0, w);
        chk("illegal_accept_wait", 64'(w), 64'd0);
        chk("err_sticky_set", 64'(err_len), 64'd1);
        send(4, 32'h0, 32'h0, 4'd7, 32'hF, w);
        wait_idle();
        chk("err_sticky_hold", 64'(err_len), 64'd1);

        // Full width, slowest bit clock.
        clks_per_bit = 8'd255;
        send(32, 32'h1357_9BDF, 32'h0, 4'd12, 32'hDEAD_BEEF, w);
        wait_idle();

        // Reset in the middle of a wait.
        clks_per_bit = 8'd4;
        send(16, 32'h0, 32'h0, 4'd6, 32'hCAFE, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (xfer_length == 0 && n < LIMIT);
        if (n >= LIMIT) note_fail("reset_pulse_wait");
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_xfer_len", 64'(xfer_length), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err", 64'(err_len), 64'd0);
        xq.delete();
        rq.delete();
        pend    = 0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send(10, 32'h0, 32'h3, 4'd4, 32'h3FF, w);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                wait_idle();
                clks_per_bit = 8'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 7) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0
                      : int'($urandom_range(33, 60));
            else
                len = int'($urandom_range(1, 32));
            m = $urandom();
            if ($urandom_range(0, 3) == 0) m = 32'hFFFF_FFFF;
            send(len, $urandom(), m, 4'($urandom()), $urandom(), w);
        end
        wait_idle();
        chk("xq_empty", 64'(xq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
